// File: rtl/alarm_pkg.sv
// Shared types and constants for the multi-channel alarm bank.
// Channel FSM encoding plus small elaboration-time helpers.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_t;

  localparam int HOUR_MAX    = 23;
  localparam int MIN_MAX     = 59;
  localparam int SEC_PER_MIN = 60;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Channel-select width; a single channel still needs one bit of select.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alarm_bank_if.sv
// Programming, control, readback and status bundle of the alarm bank.
// The master side drives time/program/control; the slave side is the bank.
interface alarm_bank_if
  import alarm_pkg::*;
#(
  parameter int NUM_CH = 4
);
  localparam int CH_W = ch_width(NUM_CH);

  logic [6:0]        i_hour;
  logic [6:0]        i_min;
  logic [6:0]        i_sec;
  logic              i_sec_tick;
  logic              i_wr;
  logic [CH_W-1:0]   i_wr_ch;
  logic [6:0]        i_wr_hour;
  logic [6:0]        i_wr_min;
  logic              i_wr_en;
  logic              i_stop;
  logic              i_snooze;
  logic [CH_W-1:0]   i_rd_ch;
  logic [6:0]        o_rd_hour;
  logic [6:0]        o_rd_min;
  logic              o_rd_en;
  logic              o_ring;
  logic              o_ring_valid;
  logic [CH_W-1:0]   o_ring_ch;
  logic [NUM_CH-1:0] o_snoozing;

  modport master (
    output i_hour, i_min, i_sec, i_sec_tick,
    output i_wr, i_wr_ch, i_wr_hour, i_wr_min, i_wr_en,
    output i_stop, i_snooze, i_rd_ch,
    input  o_rd_hour, o_rd_min, o_rd_en,
    input  o_ring, o_ring_valid, o_ring_ch, o_snoozing
  );

  modport slave (
    input  i_hour, i_min, i_sec, i_sec_tick,
    input  i_wr, i_wr_ch, i_wr_hour, i_wr_min, i_wr_en,
    input  i_stop, i_snooze, i_rd_ch,
    output o_rd_hour, o_rd_min, o_rd_en,
    output o_ring, o_ring_valid, o_ring_ch, o_snoozing
  );

endinterface

// File: rtl/alarm_bank_channel.sv
// One alarm channel: stored time/enable, edge-detected match and the
// IDLE/RING/SNOOZE machine with a shared up/down second timer.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN       = 5,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZE       = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [6:0]   i_hour,
  input  logic [6:0]   i_min,
  input  logic [6:0]   i_sec,
  input  logic         i_sec_tick,
  input  logic         i_wr,
  input  logic [6:0]   i_wr_hour,
  input  logic [6:0]   i_wr_min,
  input  logic         i_wr_en,
  input  logic         i_stop,
  input  logic         i_snooze,
  output logic [6:0]   o_alarm_hour,
  output logic [6:0]   o_alarm_min,
  output logic         o_alarm_en,
  output alarm_state_t o_state
);

  localparam int SNOOZE_SEC = SNOOZE_MIN * SEC_PER_MIN;
  localparam int TMR_W      = $clog2(max_int(SNOOZE_SEC, RING_TIMEOUT_SEC) + 1);
  localparam int CNT_W      = max_int(1, $clog2(MAX_SNOOZE + 1));

  localparam logic [TMR_W-1:0] TMR_SNOOZE    = TMR_W'(SNOOZE_SEC);
  localparam logic [TMR_W-1:0] TMR_RING_LAST = TMR_W'(RING_TIMEOUT_SEC - 1);
  localparam logic [TMR_W-1:0] TMR_ONE       = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX       = CNT_W'(MAX_SNOOZE);

  logic [6:0]       r_alarm_hour, w_alarm_hour_next;
  logic [6:0]       r_alarm_min,  w_alarm_min_next;
  logic             r_alarm_en,   w_alarm_en_next;
  alarm_state_t     r_state,      w_state_next;
  logic [TMR_W-1:0] r_timer,      w_timer_next;
  logic [CNT_W-1:0] r_snz_cnt,    w_snz_cnt_next;
  logic             r_prev_match;
  logic             w_match;
  logic             w_trigger;

  assign w_match   = r_alarm_en && (i_hour == r_alarm_hour) &&
                     (i_min == r_alarm_min) && (i_sec == 7'd0);
  assign w_trigger = w_match && !r_prev_match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alarm_hour <= '0;
      r_alarm_min  <= '0;
      r_alarm_en   <= 1'b0;
      r_state      <= IDLE;
      r_timer      <= '0;
      r_snz_cnt    <= '0;
      r_prev_match <= 1'b0;
    end else begin
      r_alarm_hour <= w_alarm_hour_next;
      r_alarm_min  <= w_alarm_min_next;
      r_alarm_en   <= w_alarm_en_next;
      r_state      <= w_state_next;
      r_timer      <= w_timer_next;
      r_snz_cnt    <= w_snz_cnt_next;
      r_prev_match <= w_match;
    end
  end

  // Case order inside each state encodes the stop > snooze > expiry > trigger priority.
  always_comb begin
    w_alarm_hour_next = r_alarm_hour;
    w_alarm_min_next  = r_alarm_min;
    w_alarm_en_next   = r_alarm_en;
    w_state_next      = r_state;
    w_timer_next      = r_timer;
    w_snz_cnt_next    = r_snz_cnt;

    if (i_wr) begin
      w_alarm_hour_next = i_wr_hour;
      w_alarm_min_next  = i_wr_min;
      w_alarm_en_next   = i_wr_en;
      w_state_next      = IDLE;
      w_timer_next      = '0;
      w_snz_cnt_next    = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_trigger) begin
            w_state_next   = RING;
            w_timer_next   = '0;
            w_snz_cnt_next = '0;
          end
        end
        RING: begin
          if (i_stop) begin
            w_state_next = IDLE;
            w_timer_next = '0;
          end else if (i_snooze) begin
            if (r_snz_cnt == CNT_MAX) begin
              w_state_next = IDLE;
              w_timer_next = '0;
            end else begin
              w_state_next = SNOOZE;
              w_timer_next = TMR_SNOOZE;
            end
          end else if (i_sec_tick) begin
            if (r_timer >= TMR_RING_LAST) begin
              w_state_next = IDLE;
              w_timer_next = '0;
            end else begin
              w_timer_next = r_timer + TMR_ONE;
            end
          end
        end
        SNOOZE: begin
          if (i_stop) begin
            w_state_next = IDLE;
            w_timer_next = '0;
          end else if (i_sec_tick) begin
            if (r_timer <= TMR_ONE) begin
              w_state_next = RING;
              w_timer_next = '0;
              if (r_snz_cnt != CNT_MAX) begin
                w_snz_cnt_next = r_snz_cnt + CNT_W'(1);
              end
            end else begin
              w_timer_next = r_timer - TMR_ONE;
            end
          end
        end
        default: begin
          w_state_next = IDLE;
          w_timer_next = '0;
        end
      endcase
    end
  end

  assign o_alarm_hour = r_alarm_hour;
  assign o_alarm_min  = r_alarm_min;
  assign o_alarm_en   = r_alarm_en;
  assign o_state      = r_state;

endmodule

// File: rtl/alarm_bank.sv
// Multi-channel alarm bank: write decode, per-channel FSM array,
// lowest-index ringing-channel encoder and registered readback.
module alarm_bank
  import alarm_pkg::*;
#(
  parameter int NUM_CH           = 4,
  parameter int SNOOZE_MIN       = 5,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZE       = 3
) (
  input  logic         clk,
  input  logic         rst,
  alarm_bank_if.slave  bus
);

  localparam int CH_W = ch_width(NUM_CH);
  localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CH);

  logic                w_wr_valid;
  logic [NUM_CH-1:0]   w_wr_sel;
  logic [6:0]          w_alarm_hour [NUM_CH];
  logic [6:0]          w_alarm_min  [NUM_CH];
  logic [NUM_CH-1:0]   w_alarm_en;
  alarm_state_t        w_state      [NUM_CH];
  logic [NUM_CH-1:0]   w_ring;
  logic [NUM_CH-1:0]   w_snoozing;
  logic [CH_W-1:0]     w_ring_ch;
  logic [6:0]          w_rd_hour;
  logic [6:0]          w_rd_min;
  logic                w_rd_en;
  logic [6:0]          r_rd_hour;
  logic [6:0]          r_rd_min;
  logic                r_rd_en;

  // Out-of-range channel or time drops the write entirely.
  assign w_wr_valid = bus.i_wr &&
                      ({1'b0, bus.i_wr_ch} < NUM_CH_V) &&
                      (bus.i_wr_hour <= 7'(HOUR_MAX)) &&
                      (bus.i_wr_min  <= 7'(MIN_MAX));

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign w_wr_sel[gi] = w_wr_valid && (bus.i_wr_ch == CH_W'(gi));

    alarm_channel #(
      .SNOOZE_MIN       (SNOOZE_MIN),
      .RING_TIMEOUT_SEC (RING_TIMEOUT_SEC),
      .MAX_SNOOZE       (MAX_SNOOZE)
    ) u_channel (
      .clk          (clk),
      .rst          (rst),
      .i_hour       (bus.i_hour),
      .i_min        (bus.i_min),
      .i_sec        (bus.i_sec),
      .i_sec_tick   (bus.i_sec_tick),
      .i_wr         (w_wr_sel[gi]),
      .i_wr_hour    (bus.i_wr_hour),
      .i_wr_min     (bus.i_wr_min),
      .i_wr_en      (bus.i_wr_en),
      .i_stop       (bus.i_stop),
      .i_snooze     (bus.i_snooze),
      .o_alarm_hour (w_alarm_hour[gi]),
      .o_alarm_min  (w_alarm_min[gi]),
      .o_alarm_en   (w_alarm_en[gi]),
      .o_state      (w_state[gi])
    );

    assign w_ring[gi]     = (w_state[gi] == RING);
    assign w_snoozing[gi] = (w_state[gi] == SNOOZE);
  end

  // Descending scan so the lowest ringing index is the last one written.
  always_comb begin
    w_ring_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_ring[i]) begin
        w_ring_ch = CH_W'(i);
      end
    end
  end

  always_comb begin
    w_rd_hour = '0;
    w_rd_min  = '0;
    w_rd_en   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.i_rd_ch == CH_W'(i)) begin
        w_rd_hour = w_alarm_hour[i];
        w_rd_min  = w_alarm_min[i];
        w_rd_en   = w_alarm_en[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_hour <= '0;
      r_rd_min  <= '0;
      r_rd_en   <= 1'b0;
    end else begin
      r_rd_hour <= w_rd_hour;
      r_rd_min  <= w_rd_min;
      r_rd_en   <= w_rd_en;
    end
  end

  assign bus.o_ring       = |w_ring;
  assign bus.o_ring_valid = |w_ring;
  assign bus.o_ring_ch    = w_ring_ch;
  assign bus.o_snoozing   = w_snoozing;
  assign bus.o_rd_hour    = r_rd_hour;
  assign bus.o_rd_min     = r_rd_min;
  assign bus.o_rd_en      = r_rd_en;

endmodule

// File: tb/tb_alarm_bank.sv
// Self-checking bench for alarm_bank: directed scenarios then random traffic,
// every cycle compared against a seconds-remaining behavioural model.
module tb_alarm_bank;

  localparam int NCH = 4;
  localparam int SNZ = 1;
  localparam int RTO = 10;
  localparam int MXS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alarm_bank_if #(.NUM_CH(NCH)) bus ();

  alarm_bank #(
    .NUM_CH           (NCH),
    .SNOOZE_MIN       (SNZ),
    .RING_TIMEOUT_SEC (RTO),
    .MAX_SNOOZE       (MXS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model: mode 0=off, 1=ringing, 2=snoozing; left = seconds remaining in mode.
  int m_hour [NCH];
  int m_min  [NCH];
  int m_en   [NCH];
  int m_mode [NCH];
  int m_left [NCH];
  int m_used [NCH];
  int m_prev [NCH];
  int m_rd_h, m_rd_m, m_rd_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_hour[c] = 0; m_min[c] = 0; m_en[c] = 0; m_mode[c] = 0;
      m_left[c] = 0; m_used[c] = 0; m_prev[c] = 0;
    end
    m_rd_h = 0; m_rd_m = 0; m_rd_e = 0;
  endtask

  task automatic model_edge();
    int  hit [NCH];
    bit  wr_ok;
    int  rc;
    if (rst) begin
      model_reset();
      return;
    end
    rc = int'(bus.i_rd_ch);
    m_rd_h = m_hour[rc]; m_rd_m = m_min[rc]; m_rd_e = m_en[rc];
    wr_ok = bus.i_wr && (int'(bus.i_wr_ch) < NCH) &&
            (int'(bus.i_wr_hour) <= 23) && (int'(bus.i_wr_min) <= 59);
    for (int c = 0; c < NCH; c++)
      hit[c] = (m_en[c] != 0 && int'(bus.i_hour) == m_hour[c] &&
                int'(bus.i_min) == m_min[c] && bus.i_sec == 0) ? 1 : 0;
    for (int c = 0; c < NCH; c++) begin
      if (wr_ok && int'(bus.i_wr_ch) == c) begin
        m_hour[c] = int'(bus.i_wr_hour);
        m_min[c]  = int'(bus.i_wr_min);
        m_en[c]   = int'(bus.i_wr_en);
        m_mode[c] = 0;
      end else if (m_mode[c] == 1) begin
        if (bus.i_stop) m_mode[c] = 0;
        else if (bus.i_snooze) begin
          if (m_used[c] == MXS) m_mode[c] = 0;
          else begin m_mode[c] = 2; m_left[c] = SNZ * 60; end
        end else if (bus.i_sec_tick) begin
          m_left[c]--;
          if (m_left[c] == 0) m_mode[c] = 0;
        end
      end else if (m_mode[c] == 2) begin
        if (bus.i_stop) m_mode[c] = 0;
        else if (bus.i_sec_tick) begin
          m_left[c]--;
          if (m_left[c] == 0) begin m_mode[c] = 1; m_left[c] = RTO; m_used[c]++; end
        end
      end else if (hit[c] == 1 && m_prev[c] == 0) begin
        m_mode[c] = 1; m_left[c] = RTO; m_used[c] = 0;
      end
      m_prev[c] = hit[c];
    end
  endtask

  task automatic compare_all();
    int any_ring = 0;
    int low = -1;
    logic [NCH-1:0] snz = '0;
    for (int c = 0; c < NCH; c++) begin
      if (m_mode[c] == 1) begin
        any_ring = 1;
        if (low < 0) low = c;
      end
      snz[c] = (m_mode[c] == 2);
    end
    if (low < 0) low = 0;
    chk("ring", bus.o_ring, any_ring);
    chk("ring_valid", bus.o_ring_valid, any_ring);
    chk("ring_ch", bus.o_ring_ch, low);
    chk("snoozing", bus.o_snoozing, snz);
    chk("rd_hour", bus.o_rd_hour, m_rd_h);
    chk("rd_min", bus.o_rd_min, m_rd_m);
    chk("rd_en", bus.o_rd_en, m_rd_e);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    bus.i_wr = 1'b0; bus.i_stop = 1'b0; bus.i_snooze = 1'b0; bus.i_sec_tick = 1'b0;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    bus.i_hour = 7'(h); bus.i_min = 7'(m); bus.i_sec = 7'(s);
  endtask

  task automatic wr(input int ch, input int h, input int m, input bit en);
    $display("write ch%0d %0d:%0d en=%0d", ch, h, m, en);
    bus.i_wr = 1'b1; bus.i_wr_ch = 2'(ch);
    bus.i_wr_hour = 7'(h); bus.i_wr_min = 7'(m); bus.i_wr_en = en;
    step();
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      bus.i_sec_tick = 1'b1;
      step();
    end
  endtask

  initial begin
    int rises;
    logic last_ring;
    set_time(0, 0, 0);
    bus.i_sec_tick = 0; bus.i_wr = 0; bus.i_wr_ch = 0; bus.i_wr_hour = 0;
    bus.i_wr_min = 0; bus.i_wr_en = 0; bus.i_stop = 0; bus.i_snooze = 0; bus.i_rd_ch = 0;
    model_reset();

    step(); step();
    chk("reset_ring", bus.o_ring, 0);
    chk("reset_rd_en", bus.o_rd_en, 0);
    rst = 1'b0;
    step();

    $display("invalid hour write to ch0");
    wr(0, 24, 0, 1'b1);
    step();
    chk("bad_wr_hour", bus.o_rd_hour, 0);
    chk("bad_wr_en", bus.o_rd_en, 0);

    $display("ch2 07:30 trigger and timeout");
    wr(2, 7, 30, 1'b1);
    set_time(7, 29, 59); step();
    set_time(7, 30, 0);  step();
    chk("trig_ring", bus.o_ring, 1);
    chk("trig_ch", bus.o_ring_ch, 2);
    ticks(RTO - 1);
    chk("ring_before_timeout", bus.o_ring, 1);
    ticks(1);
    chk("ring_after_timeout", bus.o_ring, 0);
    for (int s = 1; s < 60; s++) begin
      set_time(7, 30, s);
      step();
    end
    chk("no_retrigger", bus.o_ring, 0);

    $display("ch1+ch3 06:00, priority and stop");
    wr(1, 6, 0, 1'b1);
    wr(3, 6, 0, 1'b1);
    set_time(5, 59, 59); step();
    set_time(6, 0, 0);   step();
    chk("both_ring_ch", bus.o_ring_ch, 1);
    bus.i_stop = 1'b1; step();
    chk("stop_ring", bus.o_ring, 0);

    $display("ch0 snooze sequence");
    wr(0, 8, 0, 1'b1);
    set_time(7, 59, 59); step();
    set_time(8, 0, 0);   step();
    chk("ch0_ring_ch", bus.o_ring_ch, 0);
    bus.i_snooze = 1'b1; step();
    chk("snz1_flag", bus.o_snoozing[0], 1);
    chk("snz1_ring", bus.o_ring, 0);
    ticks(SNZ * 60 - 1);
    chk("snz1_hold", bus.o_snoozing[0], 1);
    ticks(1);
    chk("snz1_rering", bus.o_ring, 1);
    bus.i_snooze = 1'b1; step();
    ticks(SNZ * 60);
    chk("snz2_rering", bus.o_ring, 1);
    bus.i_snooze = 1'b1; step();
    chk("snz3_stop_ring", bus.o_ring, 0);
    chk("snz3_stop_flag", bus.o_snoozing, 0);

    $display("stop and snooze together");
    set_time(8, 1, 0); step();
    set_time(8, 0, 0); step();
    chk("both_pre_ring", bus.o_ring, 1);
    bus.i_stop = 1'b1; bus.i_snooze = 1'b1; step();
    chk("both_ring", bus.o_ring, 0);
    chk("both_snz", bus.o_snoozing, 0);

    $display("rewrite ch3 while ringing");
    set_time(5, 59, 59); step();
    set_time(6, 0, 0);   step();
    bus.i_rd_ch = 2'd3;
    wr(3, 9, 15, 1'b1);
    chk("rewrite_ring_ch", bus.o_ring_ch, 1);
    step();
    chk("rewrite_rd_hour", bus.o_rd_hour, 9);
    chk("rewrite_rd_min", bus.o_rd_min, 15);
    bus.i_stop = 1'b1; step();

    $display("reset during snooze");
    set_time(7, 29, 59); step();
    set_time(7, 30, 0);  step();
    bus.i_snooze = 1'b1; step();
    chk("pre_rst_snz", bus.o_snoozing[2], 1);
    ticks(5);
    rst = 1'b1;
    #1;
    chk("async_rst_ring", bus.o_ring, 0);
    chk("async_rst_snz", bus.o_snoozing, 0);
    chk("async_rst_rd", bus.o_rd_hour, 0);
    step();
    rst = 1'b0;
    wr(2, 7, 30, 1'b1);
    rises = 0;
    last_ring = bus.o_ring;
    for (int i = 0; i < 14; i++) begin
      if (i == 8) bus.i_stop = 1'b1;
      step();
      if (bus.o_ring && !last_ring) rises++;
      last_ring = bus.o_ring;
    end
    chk("single_trigger", rises, 1);

    $display("random traffic");
    for (int n = 0; n < 3000; n++) begin
      set_time($urandom_range(6, 7), $urandom_range(0, 1), $urandom_range(0, 1));
      bus.i_sec_tick = 1'($urandom_range(0, 1));
      bus.i_stop     = ($urandom_range(0, 99) < 3);
      bus.i_snooze   = ($urandom_range(0, 99) < 8);
      bus.i_rd_ch    = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 4) begin
        bus.i_wr      = 1'b1;
        bus.i_wr_ch   = 2'($urandom_range(0, 3));
        bus.i_wr_hour = ($urandom_range(0, 9) == 0) ? 7'd24 : 7'($urandom_range(6, 7));
        bus.i_wr_min  = ($urandom_range(0, 9) == 0) ? 7'd60 : 7'($urandom_range(0, 1));
        bus.i_wr_en   = ($urandom_range(0, 3) != 0);
      end
      rst = ($urandom_range(0, 999) == 0);
      step();
      rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alarm_bank.md
# alarm_bank

Parametrised multi-channel alarm unit for the digital clock; the next generation of the single hour/min/sec alarm in the clock datapath. Holds NUM_CH independently programmable alarm times and compares each against the running time. Each channel runs its own ring/snooze state machine with auto-silence timeout and a snooze limit. It drives the buzzer enable and reports which channel is ringing for the display/controller.

## Interface
- NUM_CH, 4, number of alarm channels (1..16)
- SNOOZE_MIN, 5, snooze duration in minutes (1..30)
- RING_TIMEOUT_SEC, 60, auto-silence after this many seconds of ringing (1..255)
- MAX_SNOOZE, 3, snoozes allowed per trigger; further snooze acts as stop
- clk  in  1  system clock
- rst  in  1  reset: one clock; asynchronous, active-high
- i_hour / i_min / i_sec  in  7 each  current time, binary (0..23 / 0..59 / 0..59)
- i_sec_tick  in  1  one-cycle pulse per second
- i_wr  in  1  program strobe
- i_wr_ch  in  CH_W  channel to program; CH_W = max(1, clog2(NUM_CH))
- i_wr_hour / i_wr_min  in  7 each  alarm time to store
- i_wr_en  in  1  channel enable to store
- i_stop  in  1  pulse: dismiss all ringing/snoozing channels
- i_snooze  in  1  pulse: snooze all ringing channels
- i_rd_ch  in  CH_W  channel selected for readback
- o_rd_hour / o_rd_min  out  7 each  stored time of i_rd_ch
- o_rd_en  out  1  stored enable of i_rd_ch
- o_ring  out  1  OR of all channels in RING; to buzzer enable
- o_ring_valid  out  1  at least one channel in RING
- o_ring_ch  out  CH_W  lowest-index channel in RING (0 when none)
- o_snoozing  out  NUM_CH  per-channel SNOOZE flag

## Operation
- Per channel: alarm hour, alarm min, enable, state {IDLE, RING, SNOOZE}, second timer, snooze count, previous-match flag.
- Match = enable & i_hour==alarm_hour & i_min==alarm_min & i_sec==0. Trigger = match & !prev_match, so exactly one trigger per matching minute.
- Transitions:
  - IDLE→RING on trigger. Timer and snooze count are cleared.
  - RING: the timer counts i_sec_tick. When the timer reaches RING_TIMEOUT_SEC → IDLE.
  - RING on i_stop → IDLE.
  - RING on i_snooze → SNOOZE, and the timer loads SNOOZE_MIN*60. If the snooze count equals MAX_SNOOZE, i_snooze instead → IDLE.
  - SNOOZE: the timer decrements on i_sec_tick. When it reaches 0 → RING, the timer clears and the snooze count increments.
  - SNOOZE on i_stop → IDLE.
- A trigger arriving in RING or SNOOZE is ignored.
- Write with i_wr: stores time and enable into i_wr_ch and forces that channel to IDLE.
  - Writes with hour>23 or min>59 are dropped entirely.
  - i_wr_ch ≥ NUM_CH is dropped.
- i_wr_en=0, or clearing enable by a write, forces the channel to IDLE.
- Per-channel priority: rst > valid write to this channel > i_stop > i_snooze > timer expiry > trigger.
- i_stop and i_snooze asserted together: stop wins.
- Timer width: clog2(max(SNOOZE_MIN*60, RING_TIMEOUT_SEC)+1). The timer never wraps; it saturates at its terminal value.

## Timing
- Reset values:
  - All alarm times 0:00, all enables 0, all states IDLE, timers 0, snooze counts 0, prev_match 0.
  - Outputs: o_ring 0, o_ring_valid 0, o_ring_ch 0, o_snoozing 0, o_rd_* 0.
- Trigger latency: with match true in cycle N, the state is RING and o_ring=1 from cycle N+1.
- o_ring, o_ring_valid, o_ring_ch and o_snoozing are combinational decodes of registered state; no extra latency.
- i_stop / i_snooze / i_wr take effect at the next clock edge.
- Readback is registered: o_rd_* reflect i_rd_ch one cycle later. A write is visible on readback two cycles after the i_wr cycle.
- Timeout: RING lasts exactly RING_TIMEOUT_SEC i_sec_tick pulses, then IDLE at the edge of the last tick.
- Snooze: re-enters RING on the edge of the SNOOZE_MIN*60-th tick.
- Reset mid-ring: o_ring drops asynchronously. After release, the channel re-triggers only on a fresh match rising edge (prev_match resets to 0, so a still-true match re-triggers once).

## Structure
- Shared package alarm_pkg:
  - state encoding IDLE=2'd0, RING=2'd1, SNOOZE=2'd2
  - constants HOUR_MAX=23, MIN_MAX=59, SEC_PER_MIN=60
- Sub-module alarm_channel holds one channel's registers, FSM and timer. It is instanced NUM_CH times in a generate loop.
- The top level holds write decode, priority encoder for o_ring_ch, and readback mux/register.
- Expected size about 250 RTL lines.

## Test plan
- Bench parameters: NUM_CH=4, SNOOZE_MIN=1, RING_TIMEOUT_SEC=10, MAX_SNOOZE=2.
- Program ch2=07:30 enabled; drive time 07:29:59→07:30:00 → o_ring=1 next cycle, o_ring_ch=2. It rings exactly 10 ticks, then o_ring=0; no re-trigger during 07:30:01..07:30:59.
- Ch1 and ch3 both 06:00; at match → o_ring_ch=1. i_stop → both IDLE, o_ring=0.
- Ch0 ringing; i_snooze → o_snoozing[0]=1, o_ring=0. After 60 ticks → RING. Snooze twice more → the third snooze acts as stop, ch0 IDLE.
- i_stop and i_snooze in the same cycle while ringing → IDLE, o_snoozing=0.
- Write hour=24 to ch0 → readback unchanged (0:00, en 0). Write ch3 while it is ringing → ch3 IDLE, new time read back 2 cycles later.
- Assert rst mid-snooze → all outputs 0 immediately. Release with time still 07:30:00 and ch2 re-programmed → a single trigger.
